bw_r_irf_swr_ctl: RTL and testbench
===================================

Name: bw_r_irf_swr_ctl

Overview:
- Window save/restore sequencer for the 4-thread integer register file window store.
- Accepts per-thread window-switch requests and arbitrates them round-robin.
- Drives the single save port and single restore port of the register bank, one operation at a time, in a fixed SAVE→RESTORE order.
- Raises a per-thread busy flag so the pipeline holds register writes to a thread while its window is in flight.

Parameters:
- NUM_THREADS, 4, number of requesting threads; this block supports only 4.
- TID_BITS, 2, thread-id width.
- WIN_BITS, 3, window index width.
- ADDR_BITS, 5, bank address width = TID_BITS+WIN_BITS; address = {tid, win}.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req  in  4  per-thread request; held high until the matching ack.
- req_op  in  8  per-thread op, 2 bits per thread at [2t+1:2t]: 01 save-only, 10 restore-only, 11 swap (save then restore), 00 no-op.
- req_old_win  in  12  per-thread window to save, 3 bits per thread.
- req_new_win  in  12  per-thread window to restore, 3 bits per thread.
- ack  out  4  one-cycle completion pulse, one-hot.
- busy  out  4  thread has an operation in flight, one-hot or zero.
- save  out  1  save strobe to the bank.
- save_addr  out  5  save address.
- restore  out  1  restore strobe to the bank.
- restore_addr  out  5  restore address.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state) forces:
  - state to IDLE, round-robin pointer to 0;
  - ack, busy, save and restore to 0;
  - save_addr and restore_addr to 0.
- Reset mid-operation aborts the operation; no ack is issued.
- States: IDLE, SAVE, RESTORE, DONE.
- IDLE:
  - If any req is high, grant the first requesting thread at or after the pointer, searching upward with wrap 3→0.
  - On grant, latch tid, op, old_win and new_win, set busy[tid], and set the pointer to tid+1 mod 4.
  - Next state:
    - op 01 or 11 → SAVE;
    - op 10 → RESTORE;
    - op 00 → DONE;
    - op 11 with old_win == new_win → DONE (degenerate swap; the bank ignores same-address restore).
- SAVE:
  - save=1 for exactly one cycle, save_addr={tid,old_win}.
  - Next state: RESTORE if op=11, else DONE.
- RESTORE:
  - restore=1 for exactly one cycle, restore_addr={tid,new_win}.
  - Next state: DONE.
  - The cycle after SAVE is the bank's delayed-save write cycle; the RESTORE address always differs from the SAVE address, so no read-after-write hazard exists.
- DONE: ack[tid]=1 for one cycle, busy cleared at the same edge, next state IDLE.
- Addresses hold their last value while the strobes are low.
- Latency from the IDLE sampling edge to ack:
  - swap: 3 cycles (SAVE, RESTORE, DONE);
  - save-only or restore-only: 2 cycles;
  - no-op or degenerate swap: 1 cycle.
- The earliest next grant is the cycle after DONE. The requester must drop req in the cycle it sees ack; req still high then is treated as a new request.
- Request fields are sampled only at grant. Changes to req, req_op or window fields while busy are ignored, and a req dropped early does not abort the operation.
- Simultaneous requests from all 4 threads are served in pointer order, with no thread starved for more than 3 operations.
- At most one of save and restore is high in any cycle.
- busy is one-hot or zero.

Test Plan:
- Reset, then req=0001, op0=11, old=2, new=5 →
  - cycle+1: save=1, save_addr=00010;
  - cycle+2: restore=1, restore_addr=00101;
  - cycle+3: ack=0001;
  - busy[0]=1 from grant+1 through the ack cycle.
- req=1111 all swap, held with compliant drop on ack → acks in order 0001, 0010, 0100, 1000, each 4 cycles apart; pointer wraps to 0.
- Thread 2: op=01 old=7 → save_addr=10111 then ack next cycle, no restore. Thread 3: op=10 new=0 → restore_addr=11000 then ack, no save.
- Thread 1: op=11 with old=new=4 → no save or restore strobe, ack=0010 one cycle after grant.
- Assert reset in the RESTORE cycle of a swap → restore, busy and ack go 0 immediately and no ack follows; after release with req still high, the operation restarts from SAVE.
- req0 held with op changed mid-operation → the latched op completes unchanged; req held through ack is re-granted from IDLE.

Source files
------------

// File: rtl/bw_r_irf_swr_ctl.sv
// Window save/restore sequencer for the 4-thread integer register file window store.
// Grants thread requests round-robin and drives one save and/or restore strobe per grant.
module bw_r_irf_swr_ctl #(
  parameter int NUM_THREADS = 4,
  parameter int TID_BITS    = 2,
  parameter int WIN_BITS    = 3,
  parameter int ADDR_BITS   = TID_BITS + WIN_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_THREADS-1:0]        req,
  input  logic [2*NUM_THREADS-1:0]      req_op,
  input  logic [WIN_BITS*NUM_THREADS-1:0] req_old_win,
  input  logic [WIN_BITS*NUM_THREADS-1:0] req_new_win,
  output logic [NUM_THREADS-1:0]        ack,
  output logic [NUM_THREADS-1:0]        busy,
  output logic                          save,
  output logic [ADDR_BITS-1:0]          save_addr,
  output logic                          restore,
  output logic [ADDR_BITS-1:0]          restore_addr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SAVE = 2'b01;
  localparam logic [1:0] OP_REST = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  state_t                 state_r, state_s;
  logic [TID_BITS-1:0]    ptr_r, ptr_s;
  logic [TID_BITS-1:0]    tid_r, tid_s;
  logic [1:0]             op_r, op_s;
  logic [WIN_BITS-1:0]    old_win_r, old_win_s;
  logic [WIN_BITS-1:0]    new_win_r, new_win_s;
  logic [TID_BITS:0]      pick_s;

  logic [NUM_THREADS-1:0] ack_r, ack_s;
  logic [NUM_THREADS-1:0] busy_r, busy_s;
  logic                   save_r, save_s;
  logic                   restore_r, restore_s;
  logic [ADDR_BITS-1:0]   save_addr_r, save_addr_s;
  logic [ADDR_BITS-1:0]   restore_addr_r, restore_addr_s;

  // Returns {found, tid} of the first requester at or after ptr, wrapping upward.
  function automatic logic [TID_BITS:0] rr_pick(input logic [NUM_THREADS-1:0] r,
                                                 input logic [TID_BITS-1:0]    p);
    logic [TID_BITS:0]   res;
    logic [TID_BITS-1:0] idx;
    res = {(TID_BITS+1){1'b0}};
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      idx = p + TID_BITS'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_THREADS-1:0] tid_onehot(input logic [TID_BITS-1:0] t);
    return {{(NUM_THREADS-1){1'b0}}, 1'b1} << t;
  endfunction

  // Next-state, grant capture and next registered output values.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    tid_s     = tid_r;
    op_s      = op_r;
    old_win_s = old_win_r;
    new_win_s = new_win_r;
    pick_s    = rr_pick(req, ptr_r);

    case (state_r)
      IDLE: begin
        if (pick_s[TID_BITS]) begin
          tid_s     = pick_s[TID_BITS-1:0];
          op_s      = req_op[2*int'(tid_s) +: 2];
          old_win_s = req_old_win[WIN_BITS*int'(tid_s) +: WIN_BITS];
          new_win_s = req_new_win[WIN_BITS*int'(tid_s) +: WIN_BITS];
          ptr_s     = tid_s + {{(TID_BITS-1){1'b0}}, 1'b1};
          case (op_s)
            OP_SAVE: state_s = SAVE;
            OP_REST: state_s = RESTORE;
            // A swap onto the same window needs no bank traffic at all.
            OP_SWAP: state_s = (old_win_s == new_win_s) ? DONE : SAVE;
            OP_NOP:  state_s = DONE;
            default: state_s = DONE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      SAVE:    state_s = (op_r == OP_SWAP) ? RESTORE : DONE;
      RESTORE: state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // Outputs are derived from the state being entered so they register in lockstep.
    save_s    = (state_s == SAVE);
    restore_s = (state_s == RESTORE);
    ack_s     = (state_s == DONE) ? tid_onehot(tid_s) : {NUM_THREADS{1'b0}};
    busy_s    = (state_s != IDLE) ? tid_onehot(tid_s) : {NUM_THREADS{1'b0}};

    if (save_s) begin
      save_addr_s = {tid_s, old_win_s};
    end else begin
      save_addr_s = save_addr_r;
    end

    if (restore_s) begin
      restore_addr_s = {tid_s, new_win_s};
    end else begin
      restore_addr_s = restore_addr_r;
    end
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      ptr_r          <= {TID_BITS{1'b0}};
      tid_r          <= {TID_BITS{1'b0}};
      op_r           <= 2'b00;
      old_win_r      <= {WIN_BITS{1'b0}};
      new_win_r      <= {WIN_BITS{1'b0}};
      ack_r          <= {NUM_THREADS{1'b0}};
      busy_r         <= {NUM_THREADS{1'b0}};
      save_r         <= 1'b0;
      restore_r      <= 1'b0;
      save_addr_r    <= {ADDR_BITS{1'b0}};
      restore_addr_r <= {ADDR_BITS{1'b0}};
    end else begin
      state_r        <= state_s;
      ptr_r          <= ptr_s;
      tid_r          <= tid_s;
      op_r           <= op_s;
      old_win_r      <= old_win_s;
      new_win_r      <= new_win_s;
      ack_r          <= ack_s;
      busy_r         <= busy_s;
      save_r         <= save_s;
      restore_r      <= restore_s;
      save_addr_r    <= save_addr_s;
      restore_addr_r <= restore_addr_s;
    end
  end

  assign ack          = ack_r;
  assign busy         = busy_r;
  assign save         = save_r;
  assign save_addr    = save_addr_r;
  assign restore      = restore_r;
  assign restore_addr = restore_addr_r;

endmodule

// File: tb/tb_bw_r_irf_swr_ctl.sv
// Directed bench for bw_r_irf_swr_ctl: per-cycle vector table plus sequences
// for all-thread arbitration and reset during an operation.
module tb_bw_r_irf_swr_ctl;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [11:0] req_old_win;
  logic [11:0] req_new_win;
  logic [3:0]  ack;
  logic [3:0]  busy;
  logic        save;
  logic [4:0]  save_addr;
  logic        restore;
  logic [4:0]  restore_addr;

  int checks;
  int failures;

  bw_r_irf_swr_ctl dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_op       (req_op),
    .req_old_win  (req_old_win),
    .req_new_win  (req_new_win),
    .ack          (ack),
    .busy         (busy),
    .save         (save),
    .save_addr    (save_addr),
    .restore      (restore),
    .restore_addr (restore_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] oldw;
    logic [11:0] neww;
    logic [3:0]  ack;
    logic [3:0]  busy;
    logic        sv;
    logic [4:0]  sa;
    logic        rs;
    logic [4:0]  ra;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [7:0] o,
                       input logic [11:0] ow, input logic [11:0] nw);
    req         = r;
    req_op      = o;
    req_old_win = ow;
    req_new_win = nw;
  endtask

  initial begin
    int k;
    int last_c;
    checks   = 0;
    failures = 0;

    //        req    op     old      new      ack   busy  sv    sa      rs    ra
    vt[0]  = '{4'h1, 8'h03, 12'h002, 12'h005, 4'h0, 4'h1, 1'b1, 5'h02, 1'b0, 5'h00};
    vt[1]  = '{4'h1, 8'h03, 12'h002, 12'h005, 4'h0, 4'h1, 1'b0, 5'h02, 1'b1, 5'h05};
    vt[2]  = '{4'h1, 8'h03, 12'h002, 12'h005, 4'h1, 4'h1, 1'b0, 5'h02, 1'b0, 5'h05};
    vt[3]  = '{4'h0, 8'h00, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 5'h02, 1'b0, 5'h05};
    vt[4]  = '{4'h4, 8'h10, 12'h1C0, 12'h000, 4'h0, 4'h4, 1'b1, 5'h17, 1'b0, 5'h05};
    vt[5]  = '{4'h4, 8'h10, 12'h1C0, 12'h000, 4'h4, 4'h4, 1'b0, 5'h17, 1'b0, 5'h05};
    vt[6]  = '{4'h0, 8'h00, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 5'h17, 1'b0, 5'h05};
    vt[7]  = '{4'h8, 8'h80, 12'h000, 12'h000, 4'h0, 4'h8, 1'b0, 5'h17, 1'b1, 5'h18};
    vt[8]  = '{4'h8, 8'h80, 12'h000, 12'h000, 4'h8, 4'h8, 1'b0, 5'h17, 1'b0, 5'h18};
    vt[9]  = '{4'h0, 8'h00, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 5'h17, 1'b0, 5'h18};
    vt[10] = '{4'h2, 8'h0C, 12'h020, 12'h020, 4'h2, 4'h2, 1'b0, 5'h17, 1'b0, 5'h18};
    vt[11] = '{4'h0, 8'h00, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 5'h17, 1'b0, 5'h18};
    vt[12] = '{4'h1, 8'h01, 12'h003, 12'h000, 4'h0, 4'h1, 1'b1, 5'h03, 1'b0, 5'h18};
    vt[13] = '{4'h1, 8'h02, 12'h001, 12'h006, 4'h1, 4'h1, 1'b0, 5'h03, 1'b0, 5'h18};
    vt[14] = '{4'h1, 8'h02, 12'h001, 12'h006, 4'h0, 4'h0, 1'b0, 5'h03, 1'b0, 5'h18};
    vt[15] = '{4'h1, 8'h02, 12'h001, 12'h006, 4'h0, 4'h1, 1'b0, 5'h03, 1'b1, 5'h06};
    vt[16] = '{4'h1, 8'h02, 12'h001, 12'h006, 4'h1, 4'h1, 1'b0, 5'h03, 1'b0, 5'h06};
    vt[17] = '{4'h0, 8'h00, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 5'h03, 1'b0, 5'h06};
    vt[18] = '{4'h4, 8'h00, 12'h000, 12'h000, 4'h4, 4'h4, 1'b0, 5'h03, 1'b0, 5'h06};
    vt[19] = '{4'h0, 8'h00, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 5'h03, 1'b0, 5'h06};

    reset = 1'b1;
    drive(4'h0, 8'h00, 12'h000, 12'h000);
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_save", 32'(save), 32'h0);
    chk("rst_restore", 32'(restore), 32'h0);
    chk("rst_save_addr", 32'(save_addr), 32'h0);
    chk("rst_restore_addr", 32'(restore_addr), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].req, vt[i].op, vt[i].oldw, vt[i].neww);
      tick();
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vt[i].ack));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_save", i), 32'(save), 32'(vt[i].sv));
      chk($sformatf("v%0d_save_addr", i), 32'(save_addr), 32'(vt[i].sa));
      chk($sformatf("v%0d_restore", i), 32'(restore), 32'(vt[i].rs));
      chk($sformatf("v%0d_restore_addr", i), 32'(restore_addr), 32'(vt[i].ra));
    end

    // All four threads request swaps at once; each drops req on its ack.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(4'hF, 8'hFF, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd7, 3'd6, 3'd5, 3'd4});
    k = 0;
    last_c = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      tick();
      chk("rr_one_strobe", 32'(save & restore), 32'h0);
      if (save) begin
        chk("rr_save_addr", 32'(save_addr), 32'({k[1:0], k[2:0]}));
      end
      if (ack != 4'h0) begin
        chk("rr_ack_order", 32'(ack), 32'(4'h1 << k));
        if (k == 0) begin
          chk("rr_first_latency", 32'(c), 32'd2);
        end else begin
          chk("rr_ack_spacing", 32'(c - last_c), 32'd4);
        end
        last_c = c;
        k++;
        req = req & ~ack;
      end
    end
    chk("rr_all_acked", 32'(k), 32'd4);

    // Pointer wrapped to 0: thread 0 beats thread 3; reset lands in RESTORE.
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    drive(4'h9, 8'hC3, 12'h001, 12'hA02);
    tick();
    chk("wrap_save", 32'(save), 32'h1);
    chk("wrap_save_addr", 32'(save_addr), 32'h01);
    tick();
    chk("pre_rst_restore", 32'(restore), 32'h1);
    chk("pre_rst_restore_addr", 32'(restore_addr), 32'h02);
    reset = 1'b1;
    #1;
    chk("mid_rst_restore", 32'(restore), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_restore_addr", 32'(restore_addr), 32'h0);
    tick();
    chk("held_rst_ack", 32'(ack), 32'h0);
    reset = 1'b0;
    tick();
    chk("restart_save", 32'(save), 32'h1);
    chk("restart_save_addr", 32'(save_addr), 32'h01);
    chk("restart_busy", 32'(busy), 32'h1);
    tick();
    chk("restart_restore", 32'(restore), 32'h1);
    tick();
    chk("restart_ack", 32'(ack), 32'h1);
    req = 4'h0;
    tick();
    chk("final_ack", 32'(ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
